// File: rtl/conv_ctrl_pkg.sv
// rtl/conv_ctrl_pkg.sv - shared state encoding and geometry helpers for the conv unit sequencer
package conv_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        RUN  = 3'd2,
        EMIT = 3'd3,
        DONE = 3'd4
    } conv_state_t;

    // Accumulation latency: one MAC per tap plus pipeline fill and settle.
    function automatic int conv_lat(input int d, input int f);
        return d * f * f + 2;
    endfunction

    function automatic int out_dim(input int n, input int f);
        return n - f + 1;
    endfunction

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/conv_pos_counter.sv
// rtl/conv_pos_counter.sv - raster row/column window position counter
module conv_pos_counter #(
    parameter int OUT_H = 28,
    parameter int OUT_W = 28,
    parameter int RW    = 5,
    parameter int CW    = 5
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          advance,
    output logic [RW-1:0] row,
    output logic [CW-1:0] col,
    output logic          last
);

    localparam logic [RW-1:0] ROW_MAX = RW'(OUT_H - 1);
    localparam logic [CW-1:0] COL_MAX = CW'(OUT_W - 1);

    logic row_end;
    logic col_end;

    assign row_end = (row == ROW_MAX);
    assign col_end = (col == COL_MAX);
    assign last    = row_end && col_end;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            row <= '0;
            col <= '0;
        end else if (advance) begin
            if (col_end) begin
                col <= '0;
                row <= row_end ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

endmodule

// File: rtl/conv_unit_sequencer.sv
// rtl/conv_unit_sequencer.sv - sequences one conv unit over every F x F window of the input map
module conv_unit_sequencer
    import conv_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int D          = 1,
    parameter int F          = 5,
    parameter int H          = 32,
    parameter int W          = 32,
    parameter int CONV_LAT   = conv_lat(D, F),
    localparam int OUT_H     = out_dim(H, F),
    localparam int OUT_W     = out_dim(W, F),
    localparam int RW        = idx_w(OUT_H),
    localparam int CW        = idx_w(OUT_W)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [RW-1:0]         win_row,
    output logic [CW-1:0]         win_col,
    output logic                  win_load,
    output logic                  unit_reset,
    input  logic [DATA_WIDTH-1:0] unit_result,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [RW-1:0]         out_row,
    output logic [CW-1:0]         out_col
);

    localparam int CTW = $clog2(CONV_LAT) + 1;
    localparam logic [CTW-1:0] CNT_LAST = CTW'(CONV_LAT - 1);

    conv_state_t   state;
    conv_state_t   state_n;
    logic [CTW-1:0] cnt;
    logic [RW-1:0] row;
    logic [CW-1:0] col;
    logic          last;
    logic          pos_adv;
    logic          pos_clr;
    logic [RW-1:0] win_row_q;
    logic [CW-1:0] win_col_q;
    logic          accept;

    conv_pos_counter #(
        .OUT_H(OUT_H),
        .OUT_W(OUT_W),
        .RW   (RW),
        .CW   (CW)
    ) u_pos (
        .clk    (clk),
        .reset  (reset),
        .clear  (pos_clr),
        .advance(pos_adv),
        .row    (row),
        .col    (col),
        .last   (last)
    );

    assign accept = (state == EMIT) && out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            out_data  <= '0;
            out_row   <= '0;
            out_col   <= '0;
            win_row_q <= '0;
            win_col_q <= '0;
        end else begin
            state <= state_n;
            if (state == LOAD) begin
                cnt       <= '0;
                win_row_q <= row;
                win_col_q <= col;
            end else if (state == RUN) begin
                cnt <= cnt + 1'b1;
            end
            if (state == RUN && cnt == CNT_LAST) begin
                out_data <= unit_result;
                out_row  <= row;
                out_col  <= col;
            end
        end
    end

    always_comb begin
        state_n = state;
        pos_adv = 1'b0;
        pos_clr = 1'b0;
        case (state)
            IDLE: if (start) state_n = LOAD;
            LOAD: state_n = RUN;
            RUN:  if (cnt == CNT_LAST) state_n = EMIT;
            EMIT: begin
                if (accept) begin
                    pos_adv = 1'b1;
                    state_n = last ? DONE : LOAD;
                end
            end
            DONE: begin
                pos_clr = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Window address is live during LOAD and held afterwards so the builder sees a stable index.
    assign win_row    = (state == LOAD) ? row : win_row_q;
    assign win_col    = (state == LOAD) ? col : win_col_q;
    assign busy       = (state != IDLE);
    assign done       = (state == DONE);
    assign win_load   = (state == LOAD);
    assign unit_reset = (state != RUN);
    assign out_valid  = (state == EMIT);

endmodule

// File: tb/tb_conv_unit_sequencer.sv
// tb/tb_conv_unit_sequencer.sv - directed self-checking bench for conv_unit_sequencer
module tb_conv_unit_sequencer;

    localparam int DW       = 16;
    localparam int TD       = 1;
    localparam int TF       = 5;
    localparam int TH       = 6;
    localparam int TW       = 6;
    localparam int LAT      = 27;
    localparam int RWB      = 1;
    localparam int CWB      = 1;

    logic           clk;
    logic           reset;
    logic           start;
    logic           busy;
    logic           done;
    logic [RWB-1:0] win_row;
    logic [CWB-1:0] win_col;
    logic           win_load;
    logic           unit_reset;
    logic [DW-1:0]  unit_result;
    logic           out_valid;
    logic           out_ready;
    logic [DW-1:0]  out_data;
    logic [RWB-1:0] out_row;
    logic [CWB-1:0] out_col;

    int checks = 0;
    int errors = 0;

    int loads = 0;
    int dones = 0;
    int run_cnt = 0;
    bit mode6 = 0;
    int lrow[$];
    int lcol[$];
    logic [DW-1:0] outs[$];

    conv_unit_sequencer #(
        .DATA_WIDTH(DW),
        .D         (TD),
        .F         (TF),
        .H         (TH),
        .W         (TW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .win_row    (win_row),
        .win_col    (win_col),
        .win_load   (win_load),
        .unit_reset (unit_reset),
        .unit_result(unit_result),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_row    (out_row),
        .out_col    (out_col)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Conv unit stub: run_cnt mirrors cycles spent out of reset.
    always @(posedge clk) begin
        if (unit_reset) run_cnt <= 0;
        else            run_cnt <= run_cnt + 1;
    end

    always_comb begin
        unit_result = '0;
        if (mode6) begin
            if (run_cnt == LAT - 2)      unit_result = 16'h1111;
            else if (run_cnt == LAT - 1) unit_result = 16'h4A00;
            else if (run_cnt == LAT)     unit_result = 16'hFFFF;
        end else if (!unit_reset) begin
            unit_result = 16'h1000 + DW'(loads - 1);
        end
    end

    always @(negedge clk) begin
        if (win_load) begin
            loads = loads + 1;
            lrow.push_back(int'(win_row));
            lcol.push_back(int'(win_col));
        end
        if (done) dones = dones + 1;
        if (out_valid && out_ready) outs.push_back(out_data);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        loads = 0;
        dones = 0;
        lrow.delete();
        lcol.delete();
        outs.delete();
    endtask

    task automatic start_pass();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int cyc;
        cyc = 0;
        while (!done && cyc < budget) begin
            @(negedge clk);
            cyc++;
        end
        check("done_timeout", {31'd0, done}, 32'd1);
        tick();
        tick();
    endtask

    initial begin
        int first_valid;
        int done_at;
        int bad;
        int cyc;

        reset     = 1'b1;
        start     = 1'b0;
        out_ready = 1'b1;

        // 1: reset state
        tick();
        tick();
        reset = 1'b0;
        @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_unit_reset", {31'd0, unit_reset}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_data", {16'd0, out_data}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_win_load", {31'd0, win_load}, 32'd0);
        tick();

        // 2: full pass, timing and data order
        clear_logs();
        start_pass();
        first_valid = 0;
        done_at = 0;
        for (int n = 1; n <= 200 && done_at == 0; n++) begin
            @(negedge clk);
            if (out_valid && first_valid == 0) first_valid = n;
            if (done) done_at = n;
        end
        tick();
        tick();
        check("t2_first_valid", first_valid, 29);
        check("t2_done_at", done_at, 117);
        check("t2_loads", loads, 4);
        check("t2_dones", dones, 1);
        for (int i = 0; i < 4; i++) begin
            check("t2_load_pos", (i < lrow.size()) ? lrow[i] * 2 + lcol[i] : -1, i);
            check("t2_out_data", (i < outs.size()) ? {16'd0, outs[i]} : 32'hDEAD, 32'h1000 + i);
        end
        check("t2_idle_busy", {31'd0, busy}, 32'd0);

        // 3: backpressure on window (0,1)
        clear_logs();
        start_pass();
        cyc = 0;
        while (loads < 2 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        tick();
        out_ready = 1'b0;
        cyc = 0;
        while (!out_valid && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        check("t3_valid_reached", {31'd0, out_valid}, 32'd1);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid !== 1'b1 || out_data !== 16'h1001 || out_row !== 1'b0 ||
                out_col !== 1'b1 || loads != 2) bad++;
        end
        check("t3_hold_stable", bad, 0);
        tick();
        out_ready = 1'b1;
        wait_done(300);
        check("t3_loads", loads, 4);
        check("t3_out1", (outs.size() > 1) ? {16'd0, outs[1]} : 32'hDEAD, 32'h1001);
        check("t3_dones", dones, 1);

        // 4: start while busy is ignored
        clear_logs();
        start_pass();
        cyc = 0;
        while (!(loads == 3 && !unit_reset) && cyc < 300) begin
            @(negedge clk);
            cyc++;
        end
        tick();
        start_pass();
        wait_done(300);
        repeat (40) tick();
        check("t4_loads", loads, 4);
        check("t4_dones", dones, 1);
        check("t4_busy", {31'd0, busy}, 32'd0);

        // 5: reset mid-RUN
        clear_logs();
        start_pass();
        cyc = 0;
        while (!(loads == 1 && run_cnt == 10 && !unit_reset) && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        check("t5_busy", {31'd0, busy}, 32'd0);
        check("t5_unit_reset", {31'd0, unit_reset}, 32'd1);
        check("t5_out_valid", {31'd0, out_valid}, 32'd0);
        tick();
        clear_logs();
        start_pass();
        wait_done(300);
        check("t5_first_pos", (lrow.size() > 0) ? lrow[0] * 2 + lcol[0] : -1, 0);
        check("t5_out0", (outs.size() > 0) ? {16'd0, outs[0]} : 32'hDEAD, 32'h1000);
        check("t5_loads", loads, 4);

        // 6: capture exactly at counter == CONV_LAT-1
        clear_logs();
        mode6 = 1'b1;
        start_pass();
        wait_done(300);
        check("t6_out0", (outs.size() > 0) ? {16'd0, outs[0]} : 32'hDEAD, 32'h4A00);
        check("t6_out3", (outs.size() > 3) ? {16'd0, outs[3]} : 32'hDEAD, 32'h4A00);
        mode6 = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/conv_unit_sequencer.md
Name: conv_unit_sequencer

Overview:
- Controller that sequences one convUnit instance over every valid F x F window of an H x W x D input feature map.
- Raster order, stride 1.
- For each window it: requests the window from the external window builder, holds the conv unit in reset, releases it for the fixed accumulation latency, captures the result, and presents it downstream with a valid/ready handshake.
- Sits between the feature-map window builder and the output feature-map buffer.

Parameters:
- DATA_WIDTH, 16, width of the conv unit result and of out_data
- D, 1, input depth (channels) per window
- F, 5, filter side length
- H, 32, input map height
- W, 32, input map width
- CONV_LAT, D*F*F+2, cycles from unit_reset deassertion to a stable, valid unit_result
- OUT_H / OUT_W (localparams), H-F+1 / W-F+1, output map dimensions
- RW / CW (localparams), max(1,$clog2(OUT_H)) / max(1,$clog2(OUT_W)), row and column index widths

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- start  in  1  begin a full map pass; sampled only in IDLE
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse after the last window is accepted
- win_row  out  RW  top-left row of the requested window
- win_col  out  CW  top-left column of the requested window
- win_load  out  1  one-cycle pulse; window builder latches image/filter for (win_row, win_col)
- unit_reset  out  1  drives the conv unit reset
- unit_result  in  DATA_WIDTH  conv unit result
- out_valid  out  1  out_data/out_row/out_col valid
- out_ready  in  1  downstream accepts when out_valid and out_ready
- out_data  out  DATA_WIDTH  captured convolution result
- out_row  out  RW  output-map row of out_data
- out_col  out  CW  output-map column of out_data

Behaviour:
- Reset (synchronous; overrides everything, including mid-operation):
  - state = IDLE; row, col and counter = 0.
  - busy, done, win_load, out_valid = 0; out_data, out_row, out_col = 0; unit_reset = 1.
- IDLE: unit_reset = 1. If start is high, go to LOAD; otherwise stay.
- LOAD (1 cycle): win_load = 1, unit_reset = 1, win_row/win_col = current row/col; go to RUN and clear the counter.
- RUN (CONV_LAT cycles): unit_reset = 0; counter increments each cycle. When counter == CONV_LAT-1:
  - register unit_result into out_data;
  - register row/col into out_row/out_col;
  - go to EMIT.
- EMIT:
  - out_valid = 1 and unit_reset = 1.
  - out_data, out_row and out_col are held stable until accepted.
  - On out_valid && out_ready, advance the position:
    - col increments; when col == OUT_W-1 it wraps to 0 and row increments;
    - if the accepted window was (OUT_H-1, OUT_W-1), go to DONE;
    - otherwise go to LOAD.
  - out_valid drops in the cycle after acceptance.
- DONE (1 cycle): done = 1; row and col clear to 0; go to IDLE. start is ignored in this cycle.
- Latency:
  - start sampled at edge k; out_valid first high in cycle k+CONV_LAT+2.
  - With out_ready held high, each window costs CONV_LAT+2 cycles.
  - A full pass costs OUT_H*OUT_W*(CONV_LAT+2)+1 cycles, including DONE.
- start while busy is ignored and not queued.
- out_ready while out_valid is low has no effect.
- win_row and win_col hold their value outside LOAD.
- Counter width is $clog2(CONV_LAT)+1. The counter never wraps; it is cleared on entering RUN.

Decomposition:
- Package conv_ctrl_pkg holds:
  - state encoding: IDLE, LOAD, RUN, EMIT, DONE;
  - the CONV_LAT default formula;
  - the OUT_H/OUT_W/RW/CW derivation functions.
- One natural sub-module, conv_pos_counter: raster row/col counter with advance, clear and a last flag.
- FSM, latency counter and output register live in the top module.

Test Plan:
- All scenarios use H=W=6, D=1, F=5 (OUT 2x2, CONV_LAT=27). The bench conv-unit stub drives unit_result = 16'h1000 + window index while unit_reset = 0.
1. Reset: assert reset 2 cycles, then release -> busy=0, unit_reset=1, out_valid=0, out_data=0, done=0.
2. One start pulse, out_ready=1:
   - 4 win_load pulses at (0,0), (0,1), (1,0), (1,1);
   - first out_valid 29 cycles after start is sampled;
   - out_data sequence 1000, 1001, 1002, 1003;
   - done pulses once, 117 cycles after start.
3. out_ready=0 for 10 cycles during window (0,1) -> out_valid stays 1 and out_data=16'h1001, out_row=0, out_col=1 all stable; no win_load until acceptance.
4. start pulsed again during RUN of window 2 -> ignored; exactly 4 win_load pulses and 1 done for the pass.
5. reset asserted mid-RUN (counter=10) -> next cycle IDLE, unit_reset=1, busy=0; a subsequent start restarts at (0,0) with out_data=16'h1000.
6. Stub unit_result = 16'h4A00 at counter = CONV_LAT-1 and 16'hFFFF one cycle later -> out_data = 16'h4A00.
